gba_eeprom_bridge: RTL and testbench
====================================

Name: gba_eeprom_bridge

Overview:
- Sits directly upstream of the 1-bit serial EEPROM model, between the cartridge-space bus (DMA3 16-bit halfword accesses) and the EEPROM serial port.
- Decodes the EEPROM window and converts each halfword access into one serial bit transaction, returning bit0 on reads.
- Detects EEPROM size (6-bit vs 14-bit address) from the first qualifying DMA3 transfer length and drives the EEPROM `model` input.

Parameters:
- ADDR_W, 28, byte address width of the GBA bus (low 28 bits of the system address).
- WIN_LO_32M, 28'hDFFFF00, lowest EEPROM byte address when the ROM is 32MB.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rom_32m  in  1  cartridge ROM is 32MB (restricts the EEPROM window).
- model_cfg  in  1  fallback/forced size: 0 = 512B, 1 = 8KB.
- dma3_start  in  1  one-cycle pulse when DMA3 begins a transfer.
- dma3_len  in  14  DMA3 word count at start.
- dma3_dst_ee  in  1  DMA3 destination is the EEPROM window (i.e. a write to EEPROM).
- bus_valid  in  1  access request; held until bus_ready.
- bus_write  in  1  1 = write, 0 = read.
- bus_addr  in  ADDR_W  byte address.
- bus_wdata  in  16  write data; only bit0 is used.
- bus_ready  out  1  one-cycle completion pulse.
- bus_rdata  out  16  read data as {15'b0, bit}.
- ee_hit  out  1  combinational: bus_addr lies in the EEPROM window.
- ee_cs, ee_valid, ee_write, ee_din  out  1 each  serial EEPROM request.
- ee_ready, ee_dout  in  1 each  serial EEPROM response.
- model  out  1  size currently applied to the EEPROM.

Behaviour:
- Window decode:
  - ee_hit = bus_addr[27:24]==4'hD.
  - When rom_32m=1, additionally require bus_addr >= WIN_LO_32M.
- Reset: all outputs are 0, state is IDLE, the size-lock flag is clear, and model = model_cfg.
- FSM states: IDLE, ISSUE, WAIT, CAPT, RESP.
  - IDLE: on bus_valid & ee_hit, latch bus_write and bus_wdata[0], then go to ISSUE. A bus_valid without ee_hit is ignored; no bus_ready is produced.
  - ISSUE/WAIT: drive ee_cs=1, ee_valid=1, ee_write=latched write, ee_din=latched bit. Hold these until ee_ready=1 is sampled. On ee_ready, writes go to RESP and reads go to CAPT.
  - CAPT: ee_valid=0. Sample ee_dout, because the EEPROM output is registered one cycle after the handshake. Go to RESP.
  - RESP: bus_ready=1 for exactly one cycle, and bus_rdata holds the captured bit (0 for writes). Return to IDLE.
  - bus_rdata holds its last value outside RESP.
- Latency with an immediately ready EEPROM:
  - Write: request to bus_ready = 3 cycles (IDLE→ISSUE→RESP).
  - Read: 4 cycles.
- Only one access is outstanding at a time. bus_addr and bus_wdata changes after latching are ignored.
- ee_valid is deasserted in every state other than ISSUE/WAIT, so the EEPROM never sees a duplicated bit.
- Size detection:
  - Evaluated on dma3_start & dma3_dst_ee while the lock is clear.
  - len 9 or 73 → model=0, set lock. len 17 or 81 → model=1, set lock.
  - Any other length leaves the lock clear and model unchanged.
  - Once locked, model is constant until reset.
- A model change never interrupts an in-flight access. A dma3_start in the same cycle as a bus request is handled independently.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous). No bus_ready is issued for the aborted access.

Optional Feature:
- GBA_EEPROM_AUTOSIZE_EN.
  - Defined: size detection as above. model_cfg only supplies the value before lock.
  - Undefined: detection logic and lock are removed, and model = model_cfg combinationally at all times.

Test Plan:
- rom_32m=0, write to 0xD000000 with wdata=16'h0001, ee_ready tied high → ee_valid=1 & ee_write=1 & ee_din=1 for one cycle; bus_ready 3 cycles after the request; bus_rdata=0.
- rom_32m=1, read at 0xDFFFEFE → ee_hit=0, no ee_valid, no bus_ready. Read at 0xDFFFF00 with ee_dout=1 in CAPT → bus_rdata=16'h0001 after 4 cycles.
- ee_ready held low for 5 cycles during a read → ee_valid stays high for 6 cycles, exactly one bus_ready, ee_dout sampled in the cycle after ee_ready.
- AUTOSIZE_EN, model_cfg=0, dma3_start with len=17 and dst_ee=1 → model=1. A subsequent len=9 start → model stays 1.
- AUTOSIZE_EN, len=40 start → model stays model_cfg and lock clear. A later len=73 start → model=0.
- rst_n pulsed low while in WAIT → ee_valid=0 and bus_ready=0 immediately. The next access completes normally with model=model_cfg.

Source files
------------

// File: rtl/gba_eeprom_bridge.sv
// -----------------------------------------------------------------------------
// gba_eeprom_bridge
//
// Purpose:
//   Bridges cartridge-space halfword accesses (DMA3 traffic) to a 1-bit serial
//   EEPROM port. Each halfword access inside the EEPROM window becomes exactly
//   one serial bit transaction. Reads return the EEPROM bit in bus_rdata[0].
//   The bridge also selects the EEPROM size (6-bit or 14-bit addressing) and
//   drives it on `model`.
//
// Optional feature macro: GBA_EEPROM_AUTOSIZE_EN
//   Defined   : the size is learned from the first DMA3 transfer into the
//               EEPROM whose length is 9/73 (512B) or 17/81 (8KB). It is then
//               locked until reset. model_cfg only applies before the lock.
//   Undefined : no detection logic; model follows model_cfg combinationally.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rom_32m               32MB ROM: EEPROM window shrinks to >= WIN_LO_32M
//   model_cfg             fallback / forced size (0 = 512B, 1 = 8KB)
//   dma3_start/len/dst_ee DMA3 start pulse, word count, destination is EEPROM
//   bus_valid/write/addr/wdata   access request (held until bus_ready)
//   bus_ready/rdata       one-cycle completion pulse, read data {15'b0, bit}
//   ee_hit                combinational window decode of bus_addr
//   ee_cs/valid/write/din serial EEPROM request
//   ee_ready/dout         serial EEPROM response (dout registered by EEPROM)
//   model                 EEPROM size currently applied
// -----------------------------------------------------------------------------
module gba_eeprom_bridge #(
    parameter int unsigned         ADDR_W     = 28,
    parameter logic [ADDR_W-1:0]   WIN_LO_32M = 28'hDFFFF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rom_32m,
    input  logic              model_cfg,
    input  logic              dma3_start,
    input  logic [13:0]       dma3_len,
    input  logic              dma3_dst_ee,
    input  logic              bus_valid,
    input  logic              bus_write,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [15:0]       bus_wdata,
    output logic              bus_ready,
    output logic [15:0]       bus_rdata,
    output logic              ee_hit,
    output logic              ee_cs,
    output logic              ee_valid,
    output logic              ee_write,
    output logic              ee_din,
    input  logic              ee_ready,
    input  logic              ee_dout,
    output logic              model
);

    // Top nibble of the byte address that selects the EEPROM region.
    localparam logic [3:0] EE_REGION = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Window decode: region 0xD, and on 32MB carts only the top 256 bytes.
    function automatic logic win_decode(input logic [ADDR_W-1:0] addr,
                                        input logic              r32);
        logic in_region;
        logic above_lo;
        in_region  = (addr[ADDR_W-1 -: 4] == EE_REGION);
        above_lo   = (addr >= WIN_LO_32M);
        win_decode = in_region & (~r32 | above_lo);
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;

    // Access latched in IDLE; later bus changes are deliberately ignored.
    logic        wr_q, wr_d;
    logic        bit_q, bit_d;

    logic        bus_ready_q, bus_ready_d;
    logic [15:0] bus_rdata_q, bus_rdata_d;
    logic        ee_cs_q, ee_cs_d;
    logic        ee_valid_q, ee_valid_d;
    logic        ee_write_q, ee_write_d;
    logic        ee_din_q, ee_din_d;

    logic        accept_s;

    // Only bit0 of the write data is meaningful to a serial EEPROM.
    logic        unused_ok_s;

    // -------------------------------------------------------------------------
    // Window decode
    // -------------------------------------------------------------------------
    assign ee_hit   = win_decode(bus_addr, rom_32m);
    assign accept_s = (state_q == ST_IDLE) & bus_valid & ee_hit;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Writes skip CAPT because there is no bit to return.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_valid && ee_hit) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (ee_ready) begin
                    if (wr_q) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_CAPT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CAPT: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access latch: capture direction and data bit when the access is accepted.
    always_comb begin
        wr_d  = wr_q;
        bit_d = bit_q;
        if (accept_s) begin
            wr_d  = bus_write;
            bit_d = bus_wdata[0];
        end else begin
            wr_d  = wr_q;
            bit_d = bit_q;
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they belong to. ee_valid is only set for ISSUE/WAIT,
    // which guarantees the EEPROM sees each bit once.
    always_comb begin
        ee_cs_d     = 1'b0;
        ee_valid_d  = 1'b0;
        ee_write_d  = 1'b0;
        ee_din_d    = 1'b0;
        bus_ready_d = 1'b0;
        bus_rdata_d = bus_rdata_q;
        case (state_d)
            ST_ISSUE, ST_WAIT: begin
                ee_cs_d    = 1'b1;
                ee_valid_d = 1'b1;
                ee_write_d = wr_d;
                ee_din_d   = bit_d;
            end
            ST_RESP: begin
                bus_ready_d = 1'b1;
                // ee_dout is valid during CAPT (EEPROM registers it one cycle
                // after the handshake); a write arrives here from ISSUE/WAIT.
                if (state_q == ST_CAPT) begin
                    bus_rdata_d = {15'd0, ee_dout};
                end else begin
                    bus_rdata_d = 16'd0;
                end
            end
            default: begin
                bus_ready_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and access latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= 1'b0;
            bit_q       <= 1'b0;
            bus_ready_q <= 1'b0;
            bus_rdata_q <= 16'd0;
            ee_cs_q     <= 1'b0;
            ee_valid_q  <= 1'b0;
            ee_write_q  <= 1'b0;
            ee_din_q    <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            bit_q       <= bit_d;
            bus_ready_q <= bus_ready_d;
            bus_rdata_q <= bus_rdata_d;
            ee_cs_q     <= ee_cs_d;
            ee_valid_q  <= ee_valid_d;
            ee_write_q  <= ee_write_d;
            ee_din_q    <= ee_din_d;
        end
    end

    assign bus_ready = bus_ready_q;
    assign bus_rdata = bus_rdata_q;
    assign ee_cs     = ee_cs_q;
    assign ee_valid  = ee_valid_q;
    assign ee_write  = ee_write_q;
    assign ee_din    = ee_din_q;

    // -------------------------------------------------------------------------
    // EEPROM size selection
    // -------------------------------------------------------------------------
`ifdef GBA_EEPROM_AUTOSIZE_EN

    // Length decode: {recognised, size}. 9/73 words address a 512B part
    // (6-bit address read/write), 17/81 words an 8KB part (14-bit address).
    function automatic logic [1:0] size_decode(input logic [13:0] len);
        logic [1:0] r;
        case (len)
            14'd9, 14'd73:  r = 2'b10;
            14'd17, 14'd81: r = 2'b11;
            default:        r = 2'b00;
        endcase
        size_decode = r;
    endfunction

    logic       lock_q, lock_d;
    logic       size_q, size_d;
    logic [1:0] dec_s;

    assign dec_s = size_decode(dma3_len);

    // Size detection: first recognised DMA3 length into the EEPROM locks the
    // size. Independent of the access FSM, so an in-flight bit is unaffected.
    always_comb begin
        lock_d = lock_q;
        size_d = size_q;
        if (dma3_start && dma3_dst_ee && !lock_q && dec_s[1]) begin
            lock_d = 1'b1;
            size_d = dec_s[0];
        end else begin
            lock_d = lock_q;
            size_d = size_q;
        end
    end

    // Size lock register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
            size_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            size_q <= size_d;
        end
    end

    // Before the lock the configured fallback size is applied.
    assign model       = lock_q ? size_q : model_cfg;
    assign unused_ok_s = ^bus_wdata[15:1];

`else

    assign model       = model_cfg;
    assign unused_ok_s = ^{bus_wdata[15:1], dma3_start, dma3_len, dma3_dst_ee};

`endif

endmodule

// File: tb/tb_gba_eeprom_bridge.sv
// -----------------------------------------------------------------------------
// tb_gba_eeprom_bridge
//   Directed + randomized bench for gba_eeprom_bridge. A reference model of
//   the window, access latencies, read data and size selection rules is kept
//   here and every DUT output is compared against it.
// -----------------------------------------------------------------------------
module tb_gba_eeprom_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_32m;
    logic        model_cfg;
    logic        dma3_start;
    logic [13:0] dma3_len;
    logic        dma3_dst_ee;
    logic        bus_valid;
    logic        bus_write;
    logic [27:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ready;
    logic [15:0] bus_rdata;
    logic        ee_hit;
    logic        ee_cs;
    logic        ee_valid;
    logic        ee_write;
    logic        ee_din;
    logic        ee_ready;
    logic        ee_dout;
    logic        model;

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    bit          lock_m;
    bit          size_m;
    logic [15:0] last_rdata;

    gba_eeprom_bridge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_32m     (rom_32m),
        .model_cfg   (model_cfg),
        .dma3_start  (dma3_start),
        .dma3_len    (dma3_len),
        .dma3_dst_ee (dma3_dst_ee),
        .bus_valid   (bus_valid),
        .bus_write   (bus_write),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata),
        .ee_hit      (ee_hit),
        .ee_cs       (ee_cs),
        .ee_valid    (ee_valid),
        .ee_write    (ee_write),
        .ee_din      (ee_din),
        .ee_ready    (ee_ready),
        .ee_dout     (ee_dout),
        .model       (model)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // EEPROM window as an address range.
    function automatic bit win_hit(input logic [27:0] a, input bit r32);
        bit in_d;
        in_d = (a >= 28'hD000000) && (a <= 28'hDFFFFFF);
        return in_d && (!r32 || a >= 28'hDFFFF00);
    endfunction

    function automatic bit exp_model();
`ifdef GBA_EEPROM_AUTOSIZE_EN
        return lock_m ? size_m : model_cfg;
`else
        return model_cfg;
`endif
    endfunction

    // Size rules: first recognised length into the EEPROM wins.
    task automatic apply_dma(input logic [13:0] len, input bit dst);
`ifdef GBA_EEPROM_AUTOSIZE_EN
        if (dst && !lock_m) begin
            if (len == 14'd9 || len == 14'd73) begin
                lock_m = 1'b1; size_m = 1'b0;
            end else if (len == 14'd17 || len == 14'd81) begin
                lock_m = 1'b1; size_m = 1'b1;
            end
        end
`else
        if (dst && len == 14'd0) lock_m = lock_m;
`endif
    endtask

    // Called just after a negedge. Issues one DMA3 start pulse.
    task automatic dma_pulse(input logic [13:0] len, input bit dst, input string tag);
        dma3_start = 1'b1; dma3_len = len; dma3_dst_ee = dst;
        @(negedge clk);
        dma3_start = 1'b0;
        apply_dma(len, dst);
        #1;
        chk(tag, 32'(model), 32'(exp_model()));
    endtask

    // Called just after a negedge (cycle 1 = request cycle). Plays the EEPROM
    // side: ee_ready after `wt` stalled valid cycles, ee_dout valid only in
    // the cycle following the handshake (inverted otherwise).
    task automatic do_access(input bit w, input logic [27:0] a, input logic [15:0] wd,
                             input int wt, input bit dbit, input bit dodma,
                             input logic [13:0] dlen, input bit ddst, input string tag);
        bit          hit;
        bit          hs_prev;
        int          vcnt, rcnt, rcyc, bad;
        logic [15:0] rd;
        hit = win_hit(a, rom_32m);
        vcnt = 0; rcnt = 0; rcyc = 0; bad = 0; hs_prev = 1'b0; rd = 16'hxxxx;
        bus_valid = 1'b1; bus_write = w; bus_addr = a; bus_wdata = wd;
        ee_ready = (wt == 0); ee_dout = ~dbit;
        if (dodma) begin
            dma3_start = 1'b1; dma3_len = dlen; dma3_dst_ee = ddst;
        end
        #1;
        chk({tag, "_hit"}, 32'(ee_hit), 32'(hit));
        for (int c = 2; c <= wt + 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                if (dodma) apply_dma(dlen, ddst);
                dma3_start = 1'b0;
                if (hit) begin
                    bus_addr  = 28'($urandom);
                    bus_wdata = 16'($urandom);
                    bus_write = ~w;
                end
            end
            ee_dout = hs_prev ? dbit : ~dbit;
            if (ee_valid) begin
                vcnt++;
                if (ee_write !== w || ee_din !== wd[0] || ee_cs !== 1'b1) bad++;
                ee_ready = (vcnt > wt);
            end else begin
                if (ee_cs !== 1'b0) bad++;
                ee_ready = (wt == 0);
            end
            hs_prev = ee_valid && ee_ready;
            if (bus_ready) begin
                rcnt++; rcyc = c; rd = bus_rdata; bus_valid = 1'b0;
            end
        end
        bus_valid = 1'b0;
        if (hit) begin
            chk({tag, "_vcnt"}, 32'(vcnt), 32'(wt + 1));
            chk({tag, "_rcnt"}, 32'(rcnt), 32'd1);
            chk({tag, "_lat"}, 32'(rcyc), 32'((w ? 3 : 4) + wt));
            chk({tag, "_rdata"}, 32'(rd), 32'(w ? 16'd0 : {15'd0, dbit}));
            last_rdata = w ? 16'd0 : {15'd0, dbit};
        end else begin
            chk({tag, "_vcnt"}, 32'(vcnt), 32'd0);
            chk({tag, "_rcnt"}, 32'(rcnt), 32'd0);
        end
        chk({tag, "_ifc"}, 32'(bad), 32'd0);
        chk({tag, "_hold"}, 32'(bus_rdata), 32'(last_rdata));
        chk({tag, "_model"}, 32'(model), 32'(exp_model()));
    endtask

    initial begin
        bit          ready_seen;
        logic [27:0] ra;
        logic [13:0] rl;
        rst_n = 1'b0; rom_32m = 1'b0; model_cfg = 1'b0;
        dma3_start = 1'b0; dma3_len = 14'd0; dma3_dst_ee = 1'b0;
        bus_valid = 1'b0; bus_write = 1'b0; bus_addr = 28'd0; bus_wdata = 16'd0;
        ee_ready = 1'b0; ee_dout = 1'b0;
        lock_m = 1'b0; size_m = 1'b0; last_rdata = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(bus_ready), 32'd0);
        chk("rst_rdata", 32'(bus_rdata), 32'd0);
        chk("rst_valid", 32'(ee_valid), 32'd0);
        chk("rst_cs", 32'(ee_cs), 32'd0);
        chk("rst_wr_din", 32'({ee_write, ee_din}), 32'd0);
        chk("rst_model", 32'(model), 32'(model_cfg));

        // Write bit 1, EEPROM immediately ready
        rom_32m = 1'b0;
        do_access(1'b1, 28'hD000000, 16'h0001, 0, 1'b0, 1'b0, 14'd0, 1'b0, "t1_wr");

        // 32MB window boundaries
        rom_32m = 1'b1;
        do_access(1'b0, 28'hDFFFEFE, 16'h0000, 0, 1'b1, 1'b0, 14'd0, 1'b0, "t2_miss");
        do_access(1'b0, 28'hDFFFF00, 16'h0000, 0, 1'b1, 1'b0, 14'd0, 1'b0, "t2_rd");
        do_access(1'b0, 28'hDFFFFFF, 16'h0000, 0, 1'b0, 1'b0, 14'd0, 1'b0, "t2_top");
        rom_32m = 1'b0;
        do_access(1'b0, 28'hE000000, 16'h0000, 0, 1'b1, 1'b0, 14'd0, 1'b0, "t2_above");

        // Stalled EEPROM during read
        do_access(1'b0, 28'hD001234, 16'h0000, 5, 1'b1, 1'b0, 14'd0, 1'b0, "t3_stall");
        do_access(1'b1, 28'hD000002, 16'hFFFE, 2, 1'b0, 1'b0, 14'd0, 1'b0, "t3_wr0");

        // Size selection
`ifdef GBA_EEPROM_AUTOSIZE_EN
        model_cfg = 1'b0;
        dma_pulse(14'd17, 1'b0, "sz17_nodst");
        chk("sz17_nodst_c", 32'(model), 32'd0);
        dma_pulse(14'd17, 1'b1, "sz17");
        chk("sz17_c", 32'(model), 32'd1);
        dma_pulse(14'd9, 1'b1, "sz9_locked");
        chk("sz9_locked_c", 32'(model), 32'd1);
`else
        model_cfg = 1'b1;
        #1 chk("cfg1", 32'(model), 32'd1);
        dma_pulse(14'd9, 1'b1, "noauto9");
        model_cfg = 1'b0;
        #1 chk("cfg0", 32'(model), 32'd0);
`endif

        // Reset during WAIT
        @(negedge clk);
        model_cfg = 1'b0;
        bus_write = 1'b0; bus_addr = 28'hD000010; bus_valid = 1'b1; ee_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_valid_pre", 32'(ee_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        lock_m = 1'b0; last_rdata = 16'd0;
        chk("mid_valid", 32'(ee_valid), 32'd0);
        chk("mid_ready", 32'(bus_ready), 32'd0);
        chk("mid_cs", 32'(ee_cs), 32'd0);
        chk("mid_model", 32'(model), 32'd0);
        bus_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_ready || ee_valid) ready_seen = 1'b1;
        end
        chk("mid_no_ready", 32'(ready_seen), 32'd0);
        do_access(1'b0, 28'hD000010, 16'h0000, 1, 1'b1, 1'b0, 14'd0, 1'b0, "mid_next");

`ifdef GBA_EEPROM_AUTOSIZE_EN
        model_cfg = 1'b1;
        dma_pulse(14'd40, 1'b1, "sz40");
        chk("sz40_c", 32'(model), 32'd1);
        model_cfg = 1'b0;
        #1 chk("sz40_unlocked", 32'(model), 32'd0);
        model_cfg = 1'b1;
        dma_pulse(14'd73, 1'b1, "sz73");
        chk("sz73_c", 32'(model), 32'd0);
        model_cfg = 1'b1;
        #1 chk("sz73_locked", 32'(model), 32'd0);
`endif

        // Randomized accesses with occasional concurrent DMA3 starts
        @(negedge clk);
        lock_m = 1'b0; last_rdata = 16'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            rom_32m   = 1'($urandom_range(0, 1));
            model_cfg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: ra = 28'hD000000 + 28'($urandom_range(0, 28'h0FFFFFF));
                1: ra = 28'hDFFFF00 + 28'($urandom_range(0, 255));
                2: ra = 28'hDFFFEFE;
                3: ra = 28'hDFFFF00;
                4: ra = 28'hCFFFFFE;
                5: ra = 28'hE000000;
                default: ra = 28'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rl = 14'd9;
                1: rl = 14'd17;
                2: rl = 14'd73;
                3: rl = 14'd81;
                4: rl = 14'd40;
                default: rl = 14'($urandom);
            endcase
            do_access(1'($urandom_range(0, 1)), ra, 16'($urandom), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), rl,
                      1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
